drive_state_register: RTL and testbench
=======================================

Name: drive_state_register

Overview:
Registered consumer of the manual driving controller's request outputs. It owns the car's power flag, the run state and the moving state. It applies the controller's next_state, next_moving_state and manual_power requests with a one-cycle latency. It also runs the power-on hold sequence, generates blinking turn lights from steady light requests, and decodes the moving state into one-hot motor commands.

Parameters:
POWER_HOLD, 100_000_000, consecutive cycles power_btn must be high to power on (1 s at 100 MHz)
BLINK_HALF, 25_000_000, cycles per half-period of turn-light blink

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
power_btn  in  1  power-on button level, already debounced
power_off_btn  in  1  power-off button level, already debounced
global_state  in  2  mode select; 2'b00 = manual
next_state  in  2  requested run state: 00 NSTART, 01 START, 10 MOVING
next_moving_state  in  4  requested moving state: 0000 none, 0001 fwd, 0010 back, 0100 left, 1000 right
manual_power  in  1  0 = controller requests power-off
left_light_req  in  1  steady left light request
right_light_req  in  1  steady right light request
power  out  1  registered power flag
state  out  2  registered run state
moving_state  out  4  registered moving state
turn_left_light  out  1  blinking left light
turn_right_light  out  1  blinking right light
move_forward  out  1  decode of moving_state==0001
move_backward  out  1  decode of moving_state==0010
turn_left  out  1  decode of moving_state==0100
turn_right  out  1  decode of moving_state==1000

Behaviour:
- Reset, synchronous, top priority, usable mid-operation:
  - Outputs: power=0, state=00, moving_state=0000, both lights 0, all motor outputs 0.
  - Internals: hold_cnt=0, blink_cnt=0, blink_phase=1.
- Power FSM, two states: OFF and ON.
- OFF:
  - power_btn=1 and power_off_btn=0: hold_cnt increments.
  - Any other input combination: hold_cnt clears to 0.
  - Transition to ON when power_btn=1 and hold_cnt==POWER_HOLD-1. power rises on the POWER_HOLD-th consecutive high edge; hold_cnt clears.
  - In OFF, state, moving_state and the lights are held at 0.
- ON, evaluated in priority order:
  - power_off_btn=1 → OFF at the next edge.
  - global_state==00 and manual_power==0 → OFF at the next edge.
  - global_state==00 → request capture: state<=next_state, moving_state<=next_moving_state (1-cycle latency).
  - global_state!=00 → state and moving_state are held.
  - power_btn is ignored while ON.
- Entering OFF: at the same edge, state<=00, moving_state<=0000, lights 0, blink_cnt=0, blink_phase=1.
- Sanitising, applied when capturing:
  - next_state==11 captures as 00.
  - next_moving_state not one of the five legal codes captures as 0000.
  - If the captured state!=10, moving_state is forced to 0000.
- Blink:
  - blink_cnt free-runs only while ON.
  - At blink_cnt==BLINK_HALF-1, blink_cnt wraps to 0 and blink_phase toggles.
  - turn_left_light <= power & left_light_req & blink_phase. turn_right_light is the same with right_light_req.
  - Lights are registered, so there is 1 cycle from request to light.
  - Both requests asserted: both lights blink in identical phase.
  - A request changing mid-period does not reset the counter.
  - After power-on, each light is high for the first BLINK_HALF cycles of its request, provided blink_cnt aligns.
- Motor outputs:
  - Combinational decode of the registered moving_state; at most one is high.
  - All are 0 when power=0.

Test Plan:
(POWER_HOLD=10, BLINK_HALF=4 overrides)
1. Power-on hold: reset, power_btn high 9 cycles then low → power stays 0. Then power_btn high 10 cycles → power=1 after the 10th edge, state=00.
2. Move capture: power ON, global_state=00, next_state=10, next_moving_state=0001 → one edge later state=10, moving_state=0001, move_forward=1. Then next_moving_state=1000 → turn_right=1, move_forward=0.
3. Sanitising:
   - next_state=01 with next_moving_state=0100 → moving_state=0000.
   - next_state=10 with next_moving_state=0011 → moving_state=0000.
   - next_state=11 → state=00.
4. Blink: left_light_req held 1 → turn_left_light 1 for 4 cycles, 0 for 4 cycles, repeating. Both requests held → both lights have identical waveforms.
5. Power-off paths:
   - manual_power=0 with global_state=00 while MOVING → next edge power=0, state=00, moving_state=0000, all outputs 0.
   - Same with global_state=01 → power stays 1 and state is held.
   - power_off_btn=1 → power=0 next edge.
6. Mid-operation reset: rst asserted during MOVING/0100 with left light high → all outputs 0 at the next edge. Power does not return until a fresh 10-cycle power_btn hold.

Source files
------------

// File: rtl/drive_state_register_if.sv
// Bundle of controller requests, button levels and registered drive outputs
// exchanged between the manual driving controller side and the drive state
// register. All request inputs are levels sampled on the rising clock edge;
// there is no valid/ready handshake, every input is consumed every cycle.
interface drive_state_register_if;
    logic       power_btn;
    logic       power_off_btn;
    logic [1:0] global_state;
    logic [1:0] next_state;
    logic [3:0] next_moving_state;
    logic       manual_power;
    logic       left_light_req;
    logic       right_light_req;
    logic       power;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       turn_left_light;
    logic       turn_right_light;
    logic       move_forward;
    logic       move_backward;
    logic       turn_left;
    logic       turn_right;

    // Controller / stimulus side: drives requests, observes drive outputs
    modport master (
        output power_btn, power_off_btn, global_state, next_state,
               next_moving_state, manual_power, left_light_req, right_light_req,
        input  power, state, moving_state, turn_left_light, turn_right_light,
               move_forward, move_backward, turn_left, turn_right
    );

    // Drive state register side
    modport slave (
        input  power_btn, power_off_btn, global_state, next_state,
               next_moving_state, manual_power, left_light_req, right_light_req,
        output power, state, moving_state, turn_left_light, turn_right_light,
               move_forward, move_backward, turn_left, turn_right
    );
endinterface

// File: rtl/drive_state_register.sv
// Drive state register: owns the car power flag, run state and moving state.
// Runs the power-on hold sequence, captures controller requests one cycle
// late with sanitising, blinks the turn lights and decodes motor commands.
// The power FSM state is directly visible as the power output (ON == 1).
module drive_state_register #(
    parameter int POWER_HOLD = 100_000_000,
    parameter int BLINK_HALF = 25_000_000
) (
    input logic                     clk,
    input logic                     rst,
    drive_state_register_if.slave   bus
);
    localparam int HOLD_W  = $clog2(POWER_HOLD + 1);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(POWER_HOLD - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    localparam logic [1:0] ST_NSTART = 2'b00;
    localparam logic [1:0] ST_MOVING = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    typedef enum logic {
        PWR_OFF = 1'b0,
        PWR_ON  = 1'b1
    } pwr_state_e;

    pwr_state_e         pwr_q, pwr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [1:0]         state_q, state_d;
    logic [3:0]         moving_q, moving_d;
    logic               left_light_q, left_light_d;
    logic               right_light_q, right_light_d;

    logic [1:0]         cap_state;
    logic [3:0]         cap_moving;
    logic               moving_legal;

    // Sanitise the controller request before it can be captured
    always_comb begin
        cap_state    = (bus.next_state == ST_ILLEGAL) ? ST_NSTART : bus.next_state;
        moving_legal = 1'b0;
        case (bus.next_moving_state)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: moving_legal = 1'b1;
            default:                                     moving_legal = 1'b0;
        endcase
        cap_moving = (moving_legal && cap_state == ST_MOVING) ? bus.next_moving_state : 4'b0000;
    end

    // Power FSM next state, request capture and blink generation
    always_comb begin
        pwr_d         = pwr_q;
        hold_cnt_d    = hold_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        state_d       = state_q;
        moving_d      = moving_q;
        left_light_d  = left_light_q;
        right_light_d = right_light_q;

        case (pwr_q)
            PWR_OFF: begin
                // Everything driven is parked while the car is off
                state_d       = ST_NSTART;
                moving_d      = 4'b0000;
                left_light_d  = 1'b0;
                right_light_d = 1'b0;
                blink_cnt_d   = '0;
                blink_phase_d = 1'b1;
                if (bus.power_btn && !bus.power_off_btn) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        pwr_d      = PWR_ON;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else begin
                    hold_cnt_d = '0;
                end
            end
            PWR_ON: begin
                hold_cnt_d = '0;
                if (bus.power_off_btn || (bus.global_state == 2'b00 && !bus.manual_power)) begin
                    pwr_d         = PWR_OFF;
                    state_d       = ST_NSTART;
                    moving_d      = 4'b0000;
                    left_light_d  = 1'b0;
                    right_light_d = 1'b0;
                    blink_cnt_d   = '0;
                    blink_phase_d = 1'b1;
                end else begin
                    // Only manual mode may change the run/moving state
                    if (bus.global_state == 2'b00) begin
                        state_d  = cap_state;
                        moving_d = cap_moving;
                    end
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d   = '0;
                        blink_phase_d = ~blink_phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                    left_light_d  = bus.left_light_req & blink_phase_q;
                    right_light_d = bus.right_light_req & blink_phase_q;
                end
            end
            default: pwr_d = PWR_OFF;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pwr_q         <= PWR_OFF;
            hold_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            state_q       <= ST_NSTART;
            moving_q      <= 4'b0000;
            left_light_q  <= 1'b0;
            right_light_q <= 1'b0;
        end else begin
            pwr_q         <= pwr_d;
            hold_cnt_q    <= hold_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            state_q       <= state_d;
            moving_q      <= moving_d;
            left_light_q  <= left_light_d;
            right_light_q <= right_light_d;
        end
    end

    // Outputs; motor commands are a power-gated decode of the moving state
    assign bus.power            = (pwr_q == PWR_ON);
    assign bus.state            = state_q;
    assign bus.moving_state     = moving_q;
    assign bus.turn_left_light  = left_light_q;
    assign bus.turn_right_light = right_light_q;
    assign bus.move_forward     = bus.power && (moving_q == 4'b0001);
    assign bus.move_backward    = bus.power && (moving_q == 4'b0010);
    assign bus.turn_left        = bus.power && (moving_q == 4'b0100);
    assign bus.turn_right       = bus.power && (moving_q == 4'b1000);
endmodule

// File: tb/tb_drive_state_register.sv
// Directed bench for drive_state_register with short hold/blink parameters.
module tb_drive_state_register;
    localparam int POWER_HOLD = 10;
    localparam int BLINK_HALF = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    drive_state_register_if bus ();

    drive_state_register #(
        .POWER_HOLD(POWER_HOLD),
        .BLINK_HALF(BLINK_HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling/driving
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] motors();
        return {bus.move_forward, bus.move_backward, bus.turn_left, bus.turn_right};
    endfunction

    task automatic chk_all_off(input string tag);
        chk({tag, "_power"}, 8'(bus.power), 8'h0);
        chk({tag, "_state"}, 8'(bus.state), 8'h0);
        chk({tag, "_moving"}, 8'(bus.moving_state), 8'h0);
        chk({tag, "_lights"}, 8'({bus.turn_left_light, bus.turn_right_light}), 8'h0);
        chk({tag, "_motors"}, 8'(motors()), 8'h0);
    endtask

    task automatic power_on_hold();
        bus.power_btn = 1'b1;
        tick(POWER_HOLD - 1);
        chk("hold_before_last", 8'(bus.power), 8'h0);
        tick(1);
        chk("hold_last_edge", 8'(bus.power), 8'h1);
        bus.power_btn = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.power_btn         = 1'b0;
        bus.power_off_btn     = 1'b0;
        bus.global_state      = 2'b00;
        bus.next_state        = 2'b00;
        bus.next_moving_state = 4'b0000;
        bus.manual_power      = 1'b1;
        bus.left_light_req    = 1'b0;
        bus.right_light_req   = 1'b0;
        @(negedge clk);
        tick(2);
        chk_all_off("reset");
        rst = 1'b0;

        // 1. Short hold does not power on; full hold does
        bus.power_btn = 1'b1;
        tick(9);
        chk("short_hold", 8'(bus.power), 8'h0);
        bus.power_btn = 1'b0;
        tick(1);
        chk("short_hold_release", 8'(bus.power), 8'h0);
        power_on_hold();
        chk("pon_state", 8'(bus.state), 8'h0);

        // 2. Request capture with one-cycle latency
        bus.next_state = 2'b10;
        bus.next_moving_state = 4'b0001;
        tick(1);
        chk("cap_state", 8'(bus.state), 8'h2);
        chk("cap_moving_fwd", 8'(bus.moving_state), 8'h1);
        chk("motors_fwd", 8'(motors()), 8'h8);
        bus.next_moving_state = 4'b1000;
        tick(1);
        chk("motors_right", 8'(motors()), 8'h1);

        // 3. Sanitising
        bus.next_state = 2'b01;
        bus.next_moving_state = 4'b0100;
        tick(1);
        chk("san_start_state", 8'(bus.state), 8'h1);
        chk("san_start_moving", 8'(bus.moving_state), 8'h0);
        bus.next_state = 2'b10;
        bus.next_moving_state = 4'b0011;
        tick(1);
        chk("san_bad_code_state", 8'(bus.state), 8'h2);
        chk("san_bad_code_moving", 8'(bus.moving_state), 8'h0);
        bus.next_state = 2'b11;
        bus.next_moving_state = 4'b0001;
        tick(1);
        chk("san_state11", 8'(bus.state), 8'h0);
        chk("san_state11_moving", 8'(bus.moving_state), 8'h0);

        // 4. Blink: power-cycle so the blink counter starts aligned
        bus.next_state = 2'b00;
        bus.next_moving_state = 4'b0000;
        bus.power_off_btn = 1'b1;
        tick(1);
        chk("off_btn_power", 8'(bus.power), 8'h0);
        bus.power_off_btn = 1'b0;
        bus.left_light_req = 1'b1;
        power_on_hold();
        chk("blink_pon_light", 8'(bus.turn_left_light), 8'h0);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            chk($sformatf("blink_left_%0d", i), 8'(bus.turn_left_light), 8'((i % 8) < 4));
            chk($sformatf("blink_right_idle_%0d", i), 8'(bus.turn_right_light), 8'h0);
        end
        bus.right_light_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk($sformatf("blink_both_l_%0d", i), 8'(bus.turn_left_light), 8'((i % 8) < 4));
            chk($sformatf("blink_both_r_%0d", i), 8'(bus.turn_right_light), 8'((i % 8) < 4));
        end
        bus.right_light_req = 1'b0;

        // 5a. manual_power=0 in manual mode while moving powers off
        bus.next_state = 2'b10;
        bus.next_moving_state = 4'b0001;
        tick(1);
        chk("pre_mp_moving", 8'(bus.moving_state), 8'h1);
        bus.manual_power = 1'b0;
        tick(1);
        chk_all_off("mp_off");

        // 5b. manual_power=0 outside manual mode is ignored, state held
        bus.manual_power = 1'b1;
        power_on_hold();
        bus.next_state = 2'b10;
        bus.next_moving_state = 4'b0010;
        tick(1);
        chk("pre_gs_moving", 8'(bus.moving_state), 8'h2);
        bus.global_state = 2'b01;
        bus.manual_power = 1'b0;
        bus.next_state = 2'b00;
        bus.next_moving_state = 4'b0000;
        tick(2);
        chk("gs01_power", 8'(bus.power), 8'h1);
        chk("gs01_state_held", 8'(bus.state), 8'h2);
        chk("gs01_moving_held", 8'(bus.moving_state), 8'h2);
        chk("gs01_motors", 8'(motors()), 8'h4);

        // 5c. power_off_btn powers off in any mode
        bus.power_off_btn = 1'b1;
        tick(1);
        chk_all_off("offbtn");
        bus.power_off_btn = 1'b0;
        bus.global_state = 2'b00;
        bus.manual_power = 1'b1;

        // 6. Mid-operation reset
        power_on_hold();
        bus.next_state = 2'b10;
        bus.next_moving_state = 4'b0100;
        tick(1);
        chk("pre_rst_motors", 8'(motors()), 8'h2);
        chk("pre_rst_left_light", 8'(bus.turn_left_light), 8'h1);
        rst = 1'b1;
        tick(1);
        chk_all_off("mid_rst");
        rst = 1'b0;
        tick(3);
        chk("post_rst_stays_off", 8'(bus.power), 8'h0);
        power_on_hold();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
